// File: rtl/block_pkg.sv
// Shared definitions for the block drawing path: screen geometry, background
// colour and the plotter state encoding.
package block_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        PL_IDLE = 2'd0,
        PL_DRAW = 2'd1,
        PL_DONE = 2'd2
    } plot_state_e;

endpackage

// File: rtl/rect_offset_counter.sv
// Raster offset counter for a width x ROWS rectangle: cx walks 0..width-1,
// then wraps and advances cy. Next-state values are exported for registered users.
module rect_offset_counter #(
    parameter int WID_W = 5,
    parameter int CY_W  = 2,
    parameter int ROWS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WID_W-1:0] width,
    output logic [WID_W-1:0] cx,
    output logic [CY_W-1:0]  cy,
    output logic [WID_W-1:0] cx_nxt,
    output logic [CY_W-1:0]  cy_nxt,
    output logic             last
);

    logic [WID_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0]  cy_q, cy_d;
    logic             row_end;

    always_comb begin
        cx_d    = cx_q;
        cy_d    = cy_q;
        row_end = (cx_q == width - WID_W'(1));
        last    = row_end && (cy_q == CY_W'(ROWS - 1));
        // clear wins over en so a restart always begins at the origin
        if (clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = last ? '0 : cy_q + CY_W'(1);
            end else begin
                cx_d = cx_q + WID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx     = cx_q;
    assign cy     = cy_q;
    assign cx_nxt = cx_d;
    assign cy_nxt = cy_d;

endmodule

// File: rtl/block_plotter.sv
// Rectangle pixel walker feeding the VGA adapter: one pixel write per clock,
// off-screen pixels suppressed, level done_plot back to the control FSM.
module block_plotter
    import block_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int WID_W    = 5,
    parameter int BLOCK_H  = 4,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                erase,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [WID_W-1:0]    width_in,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_we,
    output logic                done_plot
);

    localparam int CY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    // Handshake: start is a level held by control for the whole PLOT/ERASE
    // state; done_plot is a level that stays up until start is seen low, and
    // start falling before done aborts the rectangle without done_plot.
    plot_state_e         state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [WID_W-1:0]    w_q, w_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
    logic                vga_we_q, vga_we_d;
    logic                done_q, done_d;

    logic                cnt_clear, cnt_en, cnt_last;
    logic [WID_W-1:0]    cx, cx_nxt;
    logic [CY_W-1:0]     cy, cy_nxt;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                drawing;

    rect_offset_counter #(
        .WID_W (WID_W),
        .CY_W  (CY_W),
        .ROWS  (BLOCK_H)
    ) u_cnt (
        .clk    (clk),
        .rst    (reset),
        .clear  (cnt_clear),
        .en     (cnt_en),
        .width  (w_q),
        .cx     (cx),
        .cy     (cy),
        .cx_nxt (cx_nxt),
        .cy_nxt (cy_nxt),
        .last   (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        col_d     = col_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            PL_IDLE: begin
                if (start) begin
                    x0_d      = x_in;
                    y0_d      = y_in;
                    w_d       = (width_in == '0) ? WID_W'(1) : width_in;
                    col_d     = erase ? COLOUR_W'(BG_COLOUR) : colour_in;
                    cnt_clear = 1'b1;
                    state_d   = PL_DRAW;
                end
            end
            PL_DRAW: begin
                if (!start) begin
                    state_d = PL_IDLE;
                end else if (cnt_last) begin
                    state_d = PL_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            PL_DONE: begin
                if (!start) begin
                    state_d = PL_IDLE;
                end
            end
            default: state_d = PL_IDLE;
        endcase

        // Outputs are registered from the pixel about to be shown; the extra
        // sum bit catches coordinate wrap as off-screen.
        drawing      = (state_d == PL_DRAW);
        sum_x        = {1'b0, x0_d} + (X_W+1)'(cx_nxt);
        sum_y        = {1'b0, y0_d} + (Y_W+1)'(cy_nxt);
        vga_x_d      = drawing ? sum_x[X_W-1:0] : '0;
        vga_y_d      = drawing ? sum_y[Y_W-1:0] : '0;
        vga_colour_d = drawing ? col_d : '0;
        vga_we_d     = drawing && (sum_x < (X_W+1)'(SCREEN_W))
                                && (sum_y < (Y_W+1)'(SCREEN_H));
        done_d       = (state_d == PL_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PL_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            col_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_we_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            w_q          <= w_d;
            col_q        <= col_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_we_q     <= vga_we_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_we     = vga_we_q;
    assign done_plot  = done_q;

endmodule

// File: tb/tb_block_plotter.sv
// Randomised scoreboard bench for block_plotter: a raster reference model
// queues expected pixel writes and a monitor pops them as writes appear.
module tb_block_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       erase;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [4:0] width_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_we;
    logic       done_plot;

    logic [17:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    block_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .erase      (erase),
        .x_in       (x_in),
        .y_in       (y_in),
        .width_in   (width_in),
        .colour_in  (colour_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_we     (vga_we),
        .done_plot  (done_plot)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the rectangle in raster order, keeping only on-screen pixels.
    task automatic push_model(input int x, input int y, input int w, input int col,
                              input bit er, input int n_max);
        int weff;
        int k;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        weff = (w == 0) ? 1 : w;
        k = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < weff; c++) begin
                if (k < n_max && (x + c) < 160 && (y + r) < 120) begin
                    px = 8'(x + c);
                    py = 7'(y + r);
                    pc = er ? 3'd0 : 3'(col);
                    exp_q.push_back({px, py, pc});
                end
                k++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && vga_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'({vga_x, vga_y, vga_colour}), 32'h3ffff);
            end else begin
                check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_inputs(input int x, input int y, input int w, input int col, input bit er);
        x_in      = 8'(x);
        y_in      = 7'(y);
        width_in  = 5'(w);
        colour_in = 3'(col);
        erase     = er;
    endtask

    // Caller is #1 after an edge with start high; the next edge is cycle 0.
    task automatic wait_done(input int w, input string name);
        int cnt;
        int weff;
        weff = (w == 0) ? 1 : w;
        cnt = 0;
        while (cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) begin
                set_inputs($urandom_range(0, 255), $urandom_range(0, 127),
                           $urandom_range(0, 31), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            end
            if (done_plot) break;
        end
        check({name, "_done_cycle"}, 32'(cnt), 32'(weff * 4 + 1));
        check({name, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic finish_rect(input int extra, input string name);
        repeat (extra) begin
            @(posedge clk);
            #1;
            check({name, "_done_held"}, 32'(done_plot), 32'd1);
            check({name, "_we_in_done"}, 32'(vga_we), 32'd0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_done_drop"}, 32'(done_plot), 32'd0);
    endtask

    task automatic run_rect(input int x, input int y, input int w, input int col,
                            input bit er, input int extra, input string name);
        set_inputs(x, y, w, col, er);
        push_model(x, y, w, col, er, 1000);
        start = 1'b1;
        wait_done(w, name);
        finish_rect(extra, name);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_x"}, 32'(vga_x), 32'd0);
        check({name, "_y"}, 32'(vga_y), 32'd0);
        check({name, "_colour"}, 32'(vga_colour), 32'd0);
        check({name, "_we"}, 32'(vga_we), 32'd0);
        check({name, "_done"}, 32'(done_plot), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_inputs(0, 0, 0, 0, 1'b0);
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_rect(10, 20, 3, 4, 1'b0, 2, "basic");
        run_rect(10, 20, 3, 4, 1'b1, 0, "erase");
        run_rect(158, 20, 4, 5, 1'b0, 1, "right_clip");
        run_rect(30, 40, 0, 6, 1'b0, 0, "zero_width");
        run_rect(50, 118, 2, 7, 1'b0, 1, "bottom_clip");
        run_rect(255, 127, 31, 2, 1'b0, 0, "wrap_clip");

        // Abort after five pixels of a 3x4 rectangle.
        set_inputs(60, 70, 3, 3, 1'b0);
        push_model(60, 70, 3, 3, 1'b0, 5);
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_we", 32'(vga_we), 32'd0);
        check("abort_done", 32'(done_plot), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_idle_done", 32'(done_plot), 32'd0);
        end
        check("abort_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_rect(60, 70, 3, 3, 1'b0, 0, "after_abort");

        // Reset in the middle of a draw, start held through release.
        set_inputs(80, 90, 5, 1, 1'b0);
        push_model(80, 90, 5, 1, 1'b0, 1000);
        start = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        set_inputs(80, 90, 5, 1, 1'b0);
        push_model(80, 90, 5, 1, 1'b0, 1000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_done(5, "after_reset");
        finish_rect(0, "after_reset");

        for (int i = 0; i < 10; i++) begin
            int x;
            int y;
            int w;
            int c;
            bit er;
            x  = (i % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(130, 165);
            y  = (i % 3 == 0) ? $urandom_range(110, 127) : $urandom_range(0, 127);
            w  = $urandom_range(0, 31);
            c  = $urandom_range(0, 7);
            er = 1'($urandom_range(0, 1));
            run_rect(x, y, w, c, er, $urandom_range(0, 3), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
